// File: rtl/ps2_dev_tx.sv
// Device-side PS/2 transmitter: queues scan-code bytes in a FIFO and serialises
// each as an 11-bit frame (start, 8 data LSB first, odd parity, stop) on ps2_clk/ps2_data.
module ps2_dev_tx #(
  parameter int CLK_DIV = 50,
  parameter int GAP     = 100,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     inhibit,
  output logic                     ps2_clk,
  output logic                     ps2_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CMAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0]   DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   GAP_LAST = CW'(GAP - 1);
  localparam logic [CNTW-1:0] FULL     = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t            state_r, state_s;
  logic [7:0]        mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNTW-1:0]   count_r;
  logic [10:0]       shift_r, shift_s;
  logic [3:0]        bit_idx_r, bit_idx_s;
  logic              phase_hi_r, phase_hi_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              ps2_clk_r, clk_s;
  logic              ps2_data_r, data_s;
  logic              busy_r, busy_s;
  logic              push_s, pop_s;
  logic [7:0]        head_s;

  assign in_ready = (count_r != FULL);
  assign push_s   = in_valid && in_ready;
  assign pop_s    = (state_r == ST_IDLE) && (count_r != {CNTW{1'b0}}) && !inhibit;
  assign head_s   = mem_r[rd_ptr_r];
  assign ps2_clk  = ps2_clk_r;
  assign ps2_data = ps2_data_r;
  assign busy     = busy_r;
  assign count    = count_r;

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNTW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // Frame sequencing: next state plus next values of the shifter, timers and line outputs
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_idx_s  = bit_idx_r;
    phase_hi_s = phase_hi_r;
    cnt_s      = cnt_r;
    clk_s      = ps2_clk_r;
    data_s     = ps2_data_r;
    busy_s     = busy_r;
    case (state_r)
      ST_IDLE: begin
        clk_s  = 1'b1;
        data_s = 1'b1;
        busy_s = 1'b0;
        if (pop_s) begin
          state_s    = ST_SEND;
          shift_s    = {1'b1, odd_parity(head_s), head_s, 1'b0};
          bit_idx_s  = 4'd0;
          phase_hi_s = 1'b1;
          cnt_s      = {CW{1'b0}};
          data_s     = 1'b0;
          busy_s     = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (cnt_r != DIV_LAST) begin
          cnt_s = cnt_r + CW'(1);
        end else if (phase_hi_r) begin
          cnt_s      = {CW{1'b0}};
          phase_hi_s = 1'b0;
          clk_s      = 1'b0;
        end else if (bit_idx_r != 4'd10) begin
          // data only moves together with the rising clock edge
          cnt_s      = {CW{1'b0}};
          phase_hi_s = 1'b1;
          clk_s      = 1'b1;
          shift_s    = {1'b1, shift_r[10:1]};
          data_s     = shift_r[1];
          bit_idx_s  = bit_idx_r + 4'd1;
        end else begin
          cnt_s   = {CW{1'b0}};
          clk_s   = 1'b1;
          data_s  = 1'b1;
          state_s = ST_GAP;
        end
      end
      ST_GAP: begin
        clk_s  = 1'b1;
        data_s = 1'b1;
        if (cnt_r != GAP_LAST) begin
          cnt_s = cnt_r + CW'(1);
        end else begin
          cnt_s   = {CW{1'b0}};
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CW{1'b0}};
        clk_s   = 1'b1;
        data_s  = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r    <= 11'h7FF;
      bit_idx_r  <= 4'd0;
      phase_hi_r <= 1'b1;
      cnt_r      <= {CW{1'b0}};
      ps2_clk_r  <= 1'b1;
      ps2_data_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      phase_hi_r <= phase_hi_s;
      cnt_r      <= cnt_s;
      ps2_clk_r  <= clk_s;
      ps2_data_r <= data_s;
      busy_r     <= busy_s;
    end
  end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Scoreboard bench for ps2_dev_tx: accepted bytes queue expected frames, a line
// monitor decodes ps2_clk/ps2_data and checks bits, edge spacing and busy length.
module tb_ps2_dev_tx;
  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       inhibit = 1'b0;
  logic       ps2_clk, ps2_data, busy;
  logic [2:0] count;

  ps2_dev_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .inhibit(inhibit), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  // monitor state
  logic        in_frame = 1'b0;
  int          nbits = 0;
  logic [10:0] cur_frame, last_frame;
  int          start_cyc, last_fall, busy_start;
  int          falls = 0;
  int          frames_done = 0;
  logic        prev_clk = 1'b1, prev_data = 1'b1, busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (bit 0 sent first)
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (($countones(d) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor and scoreboard compare
  always @(negedge clk) begin
    if (!rst) begin
      in_frame  = 1'b0;
      nbits     = 0;
      prev_clk  = 1'b1;
      prev_data = 1'b1;
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) busy_start = cyc;
      if (!busy && busy_prev) chk("busy_len", cyc - busy_start, 2*11*CLK_DIV + GAP);
      if (!in_frame && prev_data && !ps2_data && ps2_clk) begin
        in_frame  = 1'b1;
        start_cyc = cyc;
        nbits     = 0;
        starts.push_back(cyc);
      end
      if (prev_clk && !ps2_clk) begin
        falls++;
        chk("fall_in_frame", in_frame, 1);
        if (in_frame) begin
          if (nbits == 0) chk("first_fall", cyc - start_cyc, CLK_DIV);
          else            chk("fall_spacing", cyc - last_fall, 2*CLK_DIV);
          last_fall = cyc;
          cur_frame[nbits] = ps2_data;
          nbits++;
          if (nbits == 11) begin
            chk("exp_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("frame", cur_frame, frame_of(exp_q.pop_front()));
            last_frame = cur_frame;
            in_frame = 1'b0;
            nbits = 0;
            frames_done++;
          end
        end
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
      busy_prev = busy;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    if (in_ready) exp_q.push_back(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    int k = 0;
    while (frames_done < target && k < 3000) begin @(negedge clk); k++; end
    chk("wait_frames", frames_done, target);
  endtask

  task automatic wait_bits(input int b);
    int k = 0;
    while (nbits != b && k < 500) begin @(negedge clk); k++; end
    chk("wait_bits", nbits, b);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || count != 3'd0 || exp_q.size() != 0) && k < 20000) begin @(negedge clk); k++; end
    chk("wait_idle", {busy, count, exp_q.size() == 0}, {1'b0, 3'd0, 1'b1});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int f0, s0;
    // 1. reset then idle
    repeat (3) @(negedge clk);
    chk("reset_state", {ps2_clk, ps2_data, in_ready, count, busy}, 7'b1110000);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_hold", {ps2_clk, ps2_data, in_ready, count, busy}, 7'b1110000);
    end

    // 2. single byte 0x1C
    push_byte(8'h1C);
    wait_frames(1);
    chk("frame_1C", last_frame, 11'b10000111000);
    wait_idle();

    // 3. parity case 0xF0
    push_byte(8'hF0);
    wait_frames(1);
    chk("frame_F0", last_frame, 11'b11111100000);
    wait_idle();

    // 4. fill and back-pressure
    s0 = starts.size();
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    chk("fill_count", count, 3'd4);
    chk("fill_busy", busy, 1);
    chk("fill_accepted", exp_q.size(), 5);
    push_byte(8'h06);
    chk("full_ignored", {count, in_ready}, {3'd4, 1'b0});
    wait_frames(5);
    for (int i = 0; i < 4; i++)
      chk("start_spacing", starts[s0+i+1] - starts[s0+i], 22*CLK_DIV + GAP + 1);
    wait_idle();

    // 5. inhibit
    inhibit = 1'b1;
    f0 = falls;
    push_byte(8'hAA);
    repeat (30) @(negedge clk);
    chk("inh_no_clk", falls, f0);
    chk("inh_count", count, 3'd1);
    chk("inh_idle", {busy, ps2_clk, ps2_data}, 3'b011);
    inhibit = 1'b0;
    @(negedge clk);
    chk("inh_release_start", {busy, ps2_data, count}, {1'b1, 1'b0, 3'd0});
    wait_bits(5);
    inhibit = 1'b1;
    wait_frames(1);
    inhibit = 1'b0;
    wait_idle();

    // random traffic with back-pressure
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_byte(8'($urandom));
    end
    wait_idle();

    // 6. reset mid-frame with two bytes queued
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    chk("pre_reset_count", count, 3'd2);
    wait_bits(4);
    #2 rst = 1'b0;
    #1 chk("mid_reset_out", {ps2_clk, ps2_data, count, busy, in_ready}, 7'b1100001);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    f0 = falls;
    repeat (300) @(negedge clk);
    chk("post_reset_quiet", falls, f0);
    chk("post_reset_idle", {busy, count, ps2_clk, ps2_data}, 6'b000011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
